// File: rtl/seq_pipe_deser4_pkg.sv
// seq_pipe_deser4_pkg: shared widths and state encoding for the 4-byte deserializer
package seq_pipe_deser4_pkg;
  localparam int DW = 8;
  localparam int GS = 4;
  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/seq_pipe_deser4_cnt.sv
// seq_pipe_deser4_cnt: 2-bit wrapping slot counter with clear, load-1 and increment
module seq_pipe_deser4_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       ld1,
  input  logic       clr,
  output logic [1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (ld1) cnt <= 2'd1;
    else if (inc) cnt <= cnt + 2'd1;
endmodule

// File: rtl/seq_pipe_deser4.sv
// seq_pipe_deser4: collects four bytes into registered slots feeding a 4-input adder
module seq_pipe_deser4
  import seq_pipe_deser4_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_val,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [DW-1:0] out0,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2,
  output logic [DW-1:0] out3
);
  state_t        st;
  logic [1:0]    cnt;
  logic [DW-1:0] slot [GS];
  logic          byte_x, grp_x;
  assign out_val = st == FULL;
  assign in_rdy  = st == FILL || out_rdy;
  assign byte_x  = in_val && in_rdy;
  assign grp_x   = out_val && out_rdy;
  // cnt is always 0 in FULL, so slot cnt is also the out0 target of a draining write
  seq_pipe_deser4_cnt u_cnt (
    .clk  (clk),
    .rst_n(reset),
    .inc  (byte_x && st == FILL),
    .ld1  (byte_x && st == FULL),
    .clr  (grp_x && !byte_x),
    .cnt  (cnt)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= FILL;
    else if (grp_x) st <= FILL;
    else if (byte_x && cnt == 2'd3) st <= FULL;
  always_ff @(posedge clk or negedge reset)
    if (!reset) slot <= '{default: '0};
    else if (byte_x) slot[cnt] <= in_data;
  assign out0 = slot[0];
  assign out1 = slot[1];
  assign out2 = slot[2];
  assign out3 = slot[3];
endmodule

// File: tb/tb_seq_pipe_deser4.sv
// tb_seq_pipe_deser4: directed and random checks against a byte-queue scoreboard
module tb_seq_pipe_deser4;
  logic       clk = 0;
  logic       reset = 0;
  logic       in_val = 0;
  logic       in_rdy;
  logic [7:0] in_data = 0;
  logic       out_val;
  logic       out_rdy = 0;
  logic [7:0] out0, out1, out2, out3;
  logic [7:0] o [4];
  logic [7:0] q [$];
  logic       mfull = 0;
  int         mcnt = 0;
  int         checks = 0;
  int         errors = 0;

  seq_pipe_deser4 dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .out_val(out_val), .out_rdy(out_rdy), .out0(out0), .out1(out1), .out2(out2), .out3(out3)
  );

  always #5 clk = ~clk;
  assign o[0] = out0;
  assign o[1] = out1;
  assign o[2] = out2;
  assign o[3] = out3;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one cycle: drive at negedge, check state visible before the next posedge, update model
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    logic bx, gx;
    logic [7:0] s, e;
    @(negedge clk);
    in_val = v; in_data = d; out_rdy = r;
    #1;
    chk("out_val", {7'd0, out_val}, {7'd0, mfull});
    chk("in_rdy", {7'd0, in_rdy}, {7'd0, !mfull || r});
    for (int k = 0; k < (mfull ? 4 : mcnt); k++) chk($sformatf("slot%0d", k), o[k], q[k]);
    bx = v && (!mfull || r);
    gx = mfull && r;
    if (gx) begin
      s = out0 + out1 + out2 + out3;
      e = q[0] + q[1] + q[2] + q[3];
      chk("sum", s, e);
      repeat (4) void'(q.pop_front());
    end
    if (bx) q.push_back(d);
    if (mfull) begin
      if (gx) begin mfull = 0; mcnt = bx ? 1 : 0; end
    end else if (bx) begin
      if (mcnt == 3) begin mfull = 1; mcnt = 0; end
      else mcnt++;
    end
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #2 reset = 0; in_val = 0;
    #1;
    chk("rst_out0", out0, 8'h00);
    chk("rst_out1", out1, 8'h00);
    chk("rst_out2", out2, 8'h00);
    chk("rst_out3", out3, 8'h00);
    chk("rst_out_val", {7'd0, out_val}, 8'h00);
    chk("rst_in_rdy", {7'd0, in_rdy}, 8'h01);
    q.delete(); mfull = 0; mcnt = 0;
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    rst_pulse();
    // four bytes, then group visible
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    // back-to-back two groups
    rst_pulse();
    for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    // backpressure with pending EE
    rst_pulse();
    for (int i = 10; i <= 13; i++) cyc(1, 8'(i), 0);
    repeat (3) cyc(1, 8'hEE, 0);
    cyc(1, 8'hEE, 1);
    cyc(0, 0, 0);
    chk("ee_out0", out0, 8'hEE);
    // bubbles
    rst_pulse();
    cyc(1, 8'h7F, 1);
    cyc(0, 8'h55, 1);
    cyc(0, 8'h55, 1);
    cyc(1, 8'h01, 1);
    cyc(0, 8'h55, 1);
    cyc(1, 8'h80, 1);
    cyc(1, 8'hFF, 0);
    cyc(0, 0, 0);
    chk("bubble_sum", out0 + out1 + out2 + out3, 8'hFF);
    cyc(0, 0, 1);
    // reset mid-group
    rst_pulse();
    cyc(1, 8'h11, 1);
    cyc(1, 8'h22, 1);
    rst_pulse();
    cyc(1, 8'h33, 0);
    cyc(1, 8'h44, 0);
    cyc(1, 8'h55, 0);
    cyc(1, 8'h66, 0);
    cyc(0, 0, 0);
    chk("rg_out0", out0, 8'h33);
    chk("rg_out3", out3, 8'h66);
    cyc(0, 0, 1);
    // random traffic
    rst_pulse();
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    repeat (2) cyc(0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_pipe_deser4.md
SEQ_PIPE_DESER4 -- requirements
Module: seq_pipe_deser4

Interface
REQ-001: clk  input  1  — sole clock; all state updates on its rising edge.
REQ-002: reset  input  1  — asynchronous, active-low reset (asserted when 0); takes effect immediately, independent of clk.
REQ-003: in_val  input  1  — upstream byte valid.
REQ-004: in_rdy  output  1  — block can accept a byte this cycle.
REQ-005: in_data  input  8  — byte from upstream, two's-complement or unsigned (treated as raw bits).
REQ-006: out_val  output  1  — out0..out3 hold a complete 4-byte group.
REQ-007: out_rdy  input  1  — downstream 4-input adder stage accepts the group.
REQ-008: out0, out1, out2, out3  output  8 each  — registered group slots; feed the downstream adder's in0..in3 directly.

Function
REQ-009: Byte transfer SHALL occur in a cycle where in_val=1 and in_rdy=1; group transfer SHALL occur in a cycle where out_val=1 and out_rdy=1.
REQ-010: Block SHALL have two states, FILL and FULL, plus a 2-bit slot counter cnt (0..3).
REQ-011: In FILL, in_rdy SHALL be 1 and out_val SHALL be 0.
REQ-012: In FILL, on a byte transfer, in_data SHALL be written to slot cnt (cnt=0 -> out0, ..., cnt=3 -> out3) and cnt SHALL increment by 1.
REQ-013: In FILL, a byte transfer with cnt=3 SHALL set cnt to 0 and move to FULL; out_val SHALL be 1 in the next cycle (one-cycle latency from the 4th byte).
REQ-014: In FULL, out_val SHALL be 1, and out0..out3 SHALL hold stable until a group transfer occurs.
REQ-015: In FULL, in_rdy SHALL equal out_rdy (combinational), so a byte is accepted only in a cycle that also drains the group.
REQ-016: In FULL, a group transfer without a byte transfer SHALL return to FILL with cnt=0.
REQ-017: In FULL, a simultaneous group transfer and byte transfer SHALL write in_data to out0, set cnt=1 and return to FILL; sustained throughput SHALL be one byte per cycle.
REQ-018: Slots not written in the current cycle SHALL retain their values; in FILL, partially filled slots are visible on out0..out3 but SHALL NOT be qualified by out_val.
REQ-019: in_val=0 cycles (bubbles) SHALL NOT change cnt, state or slot contents.
REQ-020: Data SHALL pass bit-exact; the block performs no arithmetic and no width change.

Reset
REQ-021: While reset=0: state=FILL, cnt=0, out0..out3=8'h00, out_val=0, in_rdy=1.
REQ-022: Reset asserted mid-group or in FULL SHALL discard all collected bytes; the first transfer after reset release SHALL be treated as slot 0.

Structure
REQ-023: A shared package seq_pipe_deser4_pkg SHALL hold the data-width constant (8), the group-size constant (4), and the FILL/FULL state enum.
REQ-024: The slot counter SHALL be a single sub-module, seq_pipe_deser4_cnt (2-bit, wrap-around, increment enable, load-1 and clear inputs, async active-low reset); all other logic stays in the top module.

Verification
REQ-025: After reset, with out_rdy=1, send 01,02,03,04 on consecutive cycles -> out_val=1 the cycle after 04, with out0..3 = 01,02,03,04.
REQ-026: Back-to-back with out_rdy=1, send 01..08 continuously -> in_rdy stays 1; group {01,02,03,04}, then group {05,06,07,08} four cycles later; downstream out=8'h0A, then 8'h1A.
REQ-027: Backpressure: fill the group {0A,0B,0C,0D}, hold out_rdy=0 for 3 cycles with in_val=1 and in_data=EE -> in_rdy=0, out0..3 stable, EE not captured; with out_rdy=1, EE is captured into out0.
REQ-028: Bubbles: send 7F, idle 2 cycles, 01, idle, 80, FF -> group {7F,01,80,FF}; downstream out=8'hFF (wrap-around).
REQ-029: Reset mid-group: send 11,22, pulse reset=0 asynchronously between clock edges -> outputs go to 00 immediately; then sending 33,44,55,66 -> group {33,44,55,66}.
REQ-030: Random: 200 cycles of random in_val, out_rdy and in_data, checked against a byte-queue model; every accepted byte appears exactly once, in order, in slot order.
